tw_rom_seq_ctrl: RTL and testbench



---
 rtl/tw_rom_seq_ctrl_if.sv | 32 +++
 rtl/tw_rom_seq_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_tw_rom_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tw_rom_seq_ctrl_if.sv
// Host/ROM-side bundle for the twiddle ROM sequencer.
// master = loader/host/testbench side, slave = the sequencer.
interface tw_rom_seq_ctrl_if #(
    parameter int SC_WIDTH = 3,
    parameter int S_WIDTH  = 4,
    parameter int HDW      = 64
);
    logic                start;
    logic                load_en;
    logic                abort;
    logic                tw_valid;
    logic                tw_ready;
    logic [HDW-1:0]      tw_data;
    logic                bfly_ready;
    logic [SC_WIDTH-1:0] stage_counter;
    logic [S_WIDTH-1:0]  state;
    logic                CEN;
    logic [1:0]          ROM2_w;
    logic [HDW-1:0]      horizontal_data_out;
    logic                busy;
    logic                done;

    modport master (
        output start, load_en, abort, tw_valid, tw_data, bfly_ready,
        input  tw_ready, stage_counter, state, CEN, ROM2_w, horizontal_data_out, busy, done
    );

    modport slave (
        input  start, load_en, abort, tw_valid, tw_data, bfly_ready,
        output tw_ready, stage_counter, state, CEN, ROM2_w, horizontal_data_out, busy, done
    );
endinterface

// File: rtl/tw_rom_seq_ctrl.sv
// Twiddle ROM sequencer: buffers stage-0 halves, bursts them into the ROM, then steps all FFT stages.
// ROM-facing outputs are registered (one cycle after the decision); TW_SEQ_PERF_EN adds stall/fill-wait counters.
module tw_rom_seq_ctrl #(
    parameter int SC_WIDTH         = 3,
    parameter int S_WIDTH          = 4,
    parameter int HDW              = 64,
    parameter int STAGE_NUM        = 3,
    parameter int LOAD_WORDS       = 4,
    parameter int BLOCKS_PER_STAGE = 1024,
    parameter int GAP_CYCLES       = 13
) (
    input  logic              CLK,
    input  logic              rst,
    tw_rom_seq_ctrl_if.slave  bus
`ifdef TW_SEQ_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       fill_wait_cycles
`endif
);
    localparam int BCW = $clog2(BLOCKS_PER_STAGE);
    localparam int LCW = $clog2(LOAD_WORDS) + 1;
    localparam int IW  = $clog2(LOAD_WORDS);
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [S_WIDTH-1:0] {
        S_IDLE = 0, S_FILL = 1, S_BURST = 2, S_DRAIN = 3,
        S_RUN = 4, S_GAP = 5, S_RUN_LAST = 6, S_DONE = 7
    } st_t;

    st_t                 cur, nxt;
    logic                half;
    logic [LCW-1:0]      bcnt;
    logic [IW-1:0]       bidx;
    logic [GW-1:0]       gcnt;
    logic [BCW-1:0]      blk;
    logic [SC_WIDTH-1:0] stage;
    logic [HDW-1:0]      tw_buf [LOAD_WORDS];

    logic xfer, fill_last, burst_last, gap_last, blk_last, stage_last;

    st_t                 o_state, state_q;
    logic                o_cen, cen_q;
    logic [1:0]          o_rw, rw_q;
    logic [HDW-1:0]      o_hd, hd_q;
    logic [SC_WIDTH-1:0] o_stage, stage_q;
    logic                o_done, done_q;

    assign bus.tw_ready = (cur == S_FILL) && (bcnt < LCW'(LOAD_WORDS));
    assign bus.busy     = (cur != S_IDLE);
    assign xfer         = bus.tw_ready && bus.tw_valid;
    assign fill_last    = xfer && (bcnt == LCW'(LOAD_WORDS - 1));
    assign burst_last   = (bidx == IW'(LOAD_WORDS - 1));
    assign gap_last     = (gcnt == GW'(GAP_CYCLES - 1));
    assign blk_last     = (blk == BCW'(BLOCKS_PER_STAGE - 1));
    assign stage_last   = (stage == SC_WIDTH'(STAGE_NUM - 1));

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        if (bus.abort) begin
            nxt = S_IDLE;
        end else begin
            case (cur)
                S_IDLE:  if (bus.start) nxt = bus.load_en ? S_FILL : S_RUN;
                S_FILL:  if (fill_last) nxt = S_BURST;
                S_BURST: if (burst_last) nxt = half ? S_DRAIN : S_FILL;
                S_DRAIN: if (gap_last) nxt = S_RUN;
                S_RUN:   if (bus.bfly_ready && blk_last) nxt = stage_last ? S_DONE : S_GAP;
                S_GAP:   if (gap_last) nxt = S_RUN;
                S_DONE:  nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Next values of the registered ROM-facing outputs; abort forces the IDLE pattern.
    always_comb begin
        o_state = S_IDLE;
        o_cen   = 1'b1;
        o_rw    = 2'd0;
        o_hd    = '0;
        o_stage = '0;
        o_done  = 1'b0;
        if (!bus.abort) begin
            case (cur)
                S_FILL:  o_state = S_FILL;
                S_BURST: begin
                    o_state = S_BURST;
                    o_rw    = half ? 2'd2 : 2'd1;
                    o_hd    = tw_buf[bidx];
                end
                S_DRAIN: o_state = S_DRAIN;
                S_RUN: begin
                    o_state = (bus.bfly_ready && blk_last) ? S_RUN_LAST : S_RUN;
                    o_cen   = !bus.bfly_ready;
                    o_stage = stage;
                end
                S_GAP: begin
                    o_state = S_GAP;
                    o_stage = stage;
                end
                S_DONE: begin
                    o_state = S_DONE;
                    o_done  = 1'b1;
                end
                default: o_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cen_q   <= 1'b1;
            rw_q    <= 2'd0;
            hd_q    <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= o_state;
            cen_q   <= o_cen;
            rw_q    <= o_rw;
            hd_q    <= o_hd;
            stage_q <= o_stage;
            done_q  <= o_done;
        end
    end

    assign bus.state               = state_q;
    assign bus.CEN                 = cen_q;
    assign bus.ROM2_w              = rw_q;
    assign bus.horizontal_data_out = hd_q;
    assign bus.stage_counter       = stage_q;
    assign bus.done                = done_q;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            half  <= 1'b0;
            bcnt  <= '0;
            bidx  <= '0;
            gcnt  <= '0;
            blk   <= '0;
            stage <= '0;
        end else if (bus.abort) begin
            half  <= 1'b0;
            bcnt  <= '0;
            bidx  <= '0;
            gcnt  <= '0;
            blk   <= '0;
            stage <= '0;
        end else begin
            case (cur)
                S_IDLE: if (bus.start) begin
                    half  <= 1'b0;
                    bcnt  <= '0;
                    bidx  <= '0;
                    blk   <= '0;
                    stage <= '0;
                end
                S_FILL: if (xfer) bcnt <= bcnt + 1'b1;
                S_BURST: begin
                    if (burst_last) begin
                        bidx <= '0;
                        if (!half) begin
                            half <= 1'b1;
                            bcnt <= '0;
                        end else begin
                            gcnt <= '0;
                        end
                    end else begin
                        bidx <= bidx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    gcnt <= gap_last ? '0 : gcnt + 1'b1;
                    if (gap_last) begin
                        blk   <= '0;
                        stage <= '0;
                    end
                end
                S_RUN: if (bus.bfly_ready) begin
                    if (blk_last) begin
                        blk  <= '0;
                        gcnt <= '0;
                        if (!stage_last) stage <= stage + 1'b1;
                    end else begin
                        blk <= blk + 1'b1;
                    end
                end
                S_GAP:  gcnt <= gap_last ? '0 : gcnt + 1'b1;
                S_DONE: stage <= '0;
                default: ;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge CLK) begin
        if (xfer) tw_buf[bcnt[IW-1:0]] <= bus.tw_data;
    end

`ifdef TW_SEQ_PERF_EN
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            stall_cycles     <= '0;
            fill_wait_cycles <= '0;
        end else if (cur == S_IDLE && bus.start) begin
            stall_cycles     <= '0;
            fill_wait_cycles <= '0;
        end else begin
            if (cur == S_RUN && !bus.bfly_ready && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 1'b1;
            if (cur == S_FILL && !bus.tw_valid && fill_wait_cycles != 32'hFFFF_FFFF)
                fill_wait_cycles <= fill_wait_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// Bench for tw_rom_seq_ctrl: scenarios are generated as per-cycle records (inputs plus the
// action the sequencer must emit for that cycle) and replayed against the DUT.
module tb_tw_rom_seq_ctrl;
    localparam int LW = 4, BPS = 1024, GAP = 13, NST = 3;

    logic CLK = 1'b0;
    logic rst;
    always #5 CLK = ~CLK;

    tw_rom_seq_ctrl_if #(.SC_WIDTH(3), .S_WIDTH(4), .HDW(64)) sif ();
`ifdef TW_SEQ_PERF_EN
    logic [31:0] stall_cycles, fill_wait_cycles;
`endif

    tw_rom_seq_ctrl #(
        .SC_WIDTH(3), .S_WIDTH(4), .HDW(64), .STAGE_NUM(NST), .LOAD_WORDS(LW),
        .BLOCKS_PER_STAGE(BPS), .GAP_CYCLES(GAP)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(sif)
`ifdef TW_SEQ_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .fill_wait_cycles(fill_wait_cycles)
`endif
    );

    // ph = phase the sequencer is in during the cycle; st..dn = outputs it must emit for it.
    typedef struct {
        bit start, load_en, abort, tw_valid, bfly;
        logic [63:0] twd;
        int ph, st;
        bit cen;
        int rw;
        logic [63:0] hd;
        int stg;
        bit dn;
    } rec_t;

    rec_t        sc_q[$];
    rec_t        cr;
    int          played = 0, ci = 0;
    int          n_cmp = 0, n_bad = 0;
    int          m_stall = 0, m_fill = 0;
    int          obs_done, obs_rw1, obs_rw2, obs_st6, obs_cenlo;
    logic [63:0] words [2*LW];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, a, e);
        end
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic add(input bit s, input bit ld, input bit ab, input bit tv, input bit br,
                       input logic [63:0] twd, input int ph, input int st, input bit cen,
                       input int rw, input logic [63:0] hd, input int stg, input bit dn);
        rec_t r;
        r.start = s; r.load_en = ld; r.abort = ab; r.tw_valid = tv; r.bfly = br; r.twd = twd;
        r.ph = ph; r.st = st; r.cen = cen; r.rw = rw; r.hd = hd; r.stg = stg; r.dn = dn;
        sc_q.push_back(r);
    endtask

    task automatic gen_idle(input int n);
        for (int i = 0; i < n; i++) add(0, rb(), 0, rb(), rb(), rnd64(), 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic gen_start(input bit ld);
        add(1, ld, 0, rb(), rb(), rnd64(), 0, 0, 1, 0, 0, 0, 0);
        m_stall = 0;
        m_fill  = 0;
    endtask

    // pat=1 uses the valid pattern 1,0,1,1,0 repeating; otherwise random gaps.
    task automatic gen_fill(input int h, input bit pat);
        int cnt = 0, k = 0;
        bit tv;
        logic [63:0] d;
        while (cnt < LW) begin
            tv = pat ? ((k % 5) != 1 && (k % 5) != 4) : rb();
            d  = rnd64();
            add(0, rb(), 0, tv, rb(), d, 1, 1, 1, 0, 0, 0, 0);
            if (tv) begin
                words[h*LW + cnt] = d;
                cnt++;
            end else begin
                m_fill++;
            end
            k++;
        end
    endtask

    task automatic gen_burst(input int h, input int ab_at);
        for (int i = 0; i < LW; i++) begin
            if (i == ab_at) begin
                add(0, 0, 1, 0, 0, rnd64(), 2, 0, 1, 0, 0, 0, 0);
                return;
            end
            add(0, 0, 0, rb(), rb(), rnd64(), 2, 2, 1, (h != 0) ? 2 : 1, words[h*LW + i], 0, 0);
        end
    endtask

    task automatic gen_drain();
        for (int i = 0; i < GAP; i++) add(0, rb(), 0, rb(), rb(), rnd64(), 3, 3, 1, 0, 0, 0, 0);
    endtask

    // Every stage needs BPS ready cycles; the BPS-th one is reported as RUN_LAST.
    task automatic gen_run(input bit all_ready, input bit inj_start, input int abort_at);
        bit stop = 0;
        bit br, s_in;
        for (int s = 0; s < NST && !stop; s++) begin
            int adv = 0, j = 0;
            while (adv < BPS && !stop) begin
                if (s == 0 && j == abort_at) begin
                    add(0, 0, 1, rb(), 1, rnd64(), 4, 0, 1, 0, 0, 0, 0);
                    stop = 1;
                end else begin
                    br   = all_ready ? 1'b1 : rb();
                    s_in = inj_start && s == 1 && j == 50;
                    add(s_in, 1, 0, rb(), br, rnd64(), 4, (br && adv == BPS-1) ? 6 : 4,
                        !br, 0, 0, s, 0);
                    if (!br) m_stall++;
                    adv += br ? 1 : 0;
                end
                j++;
            end
            if (!stop && s < NST-1)
                for (int g = 0; g < GAP; g++)
                    add(0, rb(), 0, rb(), rb(), rnd64(), 5, 5, 1, 0, 0, s+1, 0);
        end
        if (!stop) add(0, rb(), 0, rb(), rb(), rnd64(), 7, 7, 1, 0, 0, 0, 1);
    endtask

    task automatic drive(input rec_t r);
        sif.start      = r.start;
        sif.load_en    = r.load_en;
        sif.abort      = r.abort;
        sif.tw_valid   = r.tw_valid;
        sif.tw_data    = r.twd;
        sif.bfly_ready = r.bfly;
    endtask

    task automatic play();
        obs_done = 0; obs_rw1 = 0; obs_rw2 = 0; obs_st6 = 0; obs_cenlo = 0;
        while (played < sc_q.size()) begin
            @(negedge CLK);
            drive(sc_q[played]);
            played++;
        end
        repeat (2) @(posedge CLK);
        #2;
        chk("drain_idx", ci, played);
    endtask

    task automatic perf_chk();
`ifdef TW_SEQ_PERF_EN
        chk("stall_cycles", stall_cycles, m_stall);
        chk("fill_wait_cycles", fill_wait_cycles, m_fill);
`endif
    endtask

    // Compare process: outputs after edge t must equal record t's action; busy/tw_ready
    // reflect the phase of the following cycle.
    always begin
        @(posedge CLK);
        #1;
        if (ci < played) begin
            cr = sc_q[ci];
            chk("state", sif.state, cr.st);
            chk("CEN", sif.CEN, cr.cen);
            chk("ROM2_w", sif.ROM2_w, cr.rw);
            chk("hdata", sif.horizontal_data_out, cr.hd);
            chk("stage_counter", sif.stage_counter, cr.stg);
            chk("done", sif.done, cr.dn);
            if (ci + 1 < sc_q.size()) begin
                chk("busy", sif.busy, sc_q[ci+1].ph != 0);
                chk("tw_ready", sif.tw_ready, sc_q[ci+1].ph == 1);
            end
            if (sif.done) obs_done++;
            if (sif.ROM2_w == 2'd1) obs_rw1++;
            if (sif.ROM2_w == 2'd2) obs_rw2++;
            if (sif.state == 4'd6) obs_st6++;
            if (!sif.CEN) obs_cenlo++;
            ci++;
        end
    end

    initial begin
        int mark;
        rec_t z;
        z = '{default: 0};
        drive(z);
        rst = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_state", sif.state, 0);
        chk("rst_CEN", sif.CEN, 1);
        chk("rst_ROM2_w", sif.ROM2_w, 0);
        chk("rst_busy", sif.busy, 0);
        chk("rst_tw_ready", sif.tw_ready, 0);
        chk("rst_done", sif.done, 0);
        @(negedge CLK);
        rst = 1'b0;

        // Load with patterned gaps, drain, randomly stalled run.
        gen_idle(2); gen_start(1);
        gen_fill(0, 1); gen_burst(0, -1);
        gen_fill(1, 1); gen_burst(1, -1);
        gen_drain(); gen_run(0, 0, -1); gen_idle(3);
        play();
        chk("s1_rw1_cycles", obs_rw1, 4);
        chk("s1_rw2_cycles", obs_rw2, 4);
        chk("s1_done_pulses", obs_done, 1);
        chk("s1_run_last", obs_st6, 3);
        perf_chk();

        // No reload, datapath always ready.
        gen_idle(2); gen_start(0);
        mark = sc_q.size();
        gen_run(1, 0, -1);
        chk("model_run_len", sc_q.size() - mark, 3*1024 + 2*13 + 1);
        chk("model_last_st", sc_q[mark+1023].st, 6);
        chk("model_gap_st", sc_q[mark+1024].st, 5);
        gen_idle(3);
        play();
        chk("s2_done_pulses", obs_done, 1);
        chk("s2_run_last", obs_st6, 3);
        chk("s2_cen_low", obs_cenlo, 3072);
        perf_chk();

        // Abort at burst word 2, then a full reload; a start during RUN is ignored.
        gen_idle(2); gen_start(1);
        gen_fill(0, 0); gen_burst(0, 2);
        gen_idle(2); gen_start(1);
        gen_fill(0, 0); gen_burst(0, -1);
        gen_fill(1, 0); gen_burst(1, -1);
        gen_drain(); gen_run(0, 1, -1); gen_idle(3);
        play();
        chk("s3_rw1_cycles", obs_rw1, 6);
        chk("s3_rw2_cycles", obs_rw2, 4);
        chk("s3_done_pulses", obs_done, 1);
        perf_chk();

        // Abort mid-RUN.
        gen_idle(2); gen_start(0); gen_run(0, 0, 300); gen_idle(3);
        play();
        chk("s4_done_pulses", obs_done, 0);
        chk("s4_run_last", obs_st6, 0);

        // Asynchronous reset while running.
        @(negedge CLK);
        z.start = 1; z.bfly = 1;
        drive(z);
        @(negedge CLK);
        z.start = 0;
        drive(z);
        repeat (40) @(posedge CLK);
        #1;
        chk("mid_state", sif.state, 4);
        chk("mid_CEN", sif.CEN, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_CEN", sif.CEN, 1);
        chk("arst_ROM2_w", sif.ROM2_w, 0);
        chk("arst_state", sif.state, 0);
        chk("arst_busy", sif.busy, 0);
        @(negedge CLK);
        rst = 1'b0;
        @(posedge CLK);
        #1;
        chk("post_rst_state", sif.state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
